cpu: RTL and testbench
======================

# cpu

Single-cycle 8-bit processor core for the virtual processor. Holds the program counter and an 8×8 register file, and decodes each 32-bit instruction. It drives operands and SELECT into the existing `alu`, writes RESULT back to the register file, and uses ZERO for branch resolution. It is the stage directly upstream and downstream of `alu`, and the instruction memory sits outside it.

## Interface
- No parameters. Widths are fixed: data 8, PC 32, register index 3, instruction 32.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  instruction word at the current PC, supplied by external memory.
- PC  out  32  byte address of the current instruction.

## Operation
- Instruction fields:
  - OPCODE = [31:24].
  - DEST = [18:16], or signed 8-bit word OFFSET = [23:16] for j/beq.
  - SRC1 = [10:8].
  - SRC2 = [2:0], or IMM = [7:0].
- Opcodes, ALU SELECT and effect:
  - 0x00 loadi: SELECT 000; rd ← IMM.
  - 0x01 mov: SELECT 000; rd ← r[SRC2].
  - 0x02 add: SELECT 001; rd ← r[SRC1] + r[SRC2].
  - 0x03 sub: SELECT 001; DATA2 = ~r[SRC2] + 1, mod 256.
  - 0x04 and: SELECT 010.
  - 0x05 or: SELECT 011.
  - 0x06 j: no write.
  - 0x07 beq: SELECT 001; computes r[SRC1] − r[SRC2]; no write.
  - 0x08 sll: SELECT 100; rd ← r[SRC1] shifted by IMM.
  - 0x09 srl: SELECT 101; same operand form as sll.
  - 0x0A sra: SELECT 110; same operand form as sll.
  - 0x0B ror: SELECT 111; same operand form as sll.
- Operand routing: DATA1 = r[SRC1]. DATA2 is either IMM (loadi, shifts) or the register/negated-register value.
- Write enable is asserted for opcodes 0x00–0x05 and 0x08–0x0B only. All 8 registers are writable, including r0.
- Next PC:
  - Default: PC+4.
  - j, and beq with ZERO=1: PC+4 + (sign_extend(OFFSET) << 2).
  - Arithmetic is 32-bit modulo 2^32. Wrap-around is permitted and not flagged.
- Undefined opcodes: no register write, no SELECT change required, PC advances by 4.
- Register file: two combinational read ports and one write port.
  - The write lands at the rising edge when enabled.
  - A read of a register in the same cycle it is written returns the old value until the edge.

## Timing
- Intra-cycle delays for simulation realism, all in ns:
  - PC register update: 1.
  - PC+4 adder: 1.
  - Branch-target adder: 2.
  - Decode: 1.
  - Register read: 2.
  - Register write: 1 after the edge.
  - Two's-complement negation: 1.
- Reference clock period: 8 ns. Every instruction completes (write-back and PC update) at the rising edge that ends its cycle. Latency is 1 cycle and there is no stall.
- Branch decision uses ZERO as settled at the edge. It must be valid at least 1 ns before the edge.
- Reset asserted (RESET=0):
  - PC = 0 and all registers = 0 immediately, with no delay and independent of CLK.
  - Any write in flight is discarded.
- Reset held low: PC stays 0 and no register writes occur.
- Reset release: the first rising edge executes the instruction at PC 0, which was already presented.
- Reset deasserted coincident with a rising edge: that edge is ignored and execution begins on the next edge.
- beq not taken and unknown opcodes behave identically for PC purposes.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants `OP_LOADI`…`OP_ROR`;
  - ALU select constants `ALU_FWD`, `ALU_ADD`, `ALU_AND`, `ALU_OR`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_ROR`;
  - field bit positions and the reset PC value.
- Sub-module `reg_file`: 8×8 storage, ports CLK, RESET, WRITE, IN[7:0], INADDR[2:0], OUT1ADDR, OUT2ADDR, OUT1[7:0], OUT2[7:0].
- `cpu` contains the PC, next-PC logic, decoder and operand muxes. It instantiates `reg_file` and `alu` unchanged.

## Test plan
- Load and add: RESET pulse, then `loadi r1,5`; `loadi r2,3`; `add r3,r1,r2` → r3=8 after the 3rd edge; PC=12.
- Subtract with wrap: r1=3, r2=5, `sub r4,r1,r2` → r4=0xFE. Next, r1=r2=7, `sub r4,r1,r2` → r4=0x00.
- Branch: r1=r2=9, `beq 2,r1,r2` at PC 0x10 → PC=0x1C. With r2=8 instead → PC=0x14, and no register changes.
- Jump backward: `j -3` (OFFSET=0xFD) at PC 0x20 → PC=0x18. Jump from PC 0 with OFFSET −1 → PC=0x00000000 (wraps to 0, valid).
- Shifts: r1=0x96.
  - `sll r2,r1,2` → 0x58.
  - `srl` by 1 → 0x4B.
  - `sra` by 1 → 0xCB.
  - `ror` by 4 → 0x69.
- Reset mid-run: assert RESET low 3 ns after an edge during an add to r5 → PC=0 and r5=0 immediately. The add result is never written. After release, execution restarts at PC 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit single-cycle core: opcodes, ALU selects,
// instruction field positions and the reset PC.
`default_nettype none

package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_SLL   = 8'h08;
  localparam logic [7:0] OP_SRL   = 8'h09;
  localparam logic [7:0] OP_SRA   = 8'h0A;
  localparam logic [7:0] OP_ROR   = 8'h0B;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_ROR = 3'b111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int DEST_MSB   = 18;
  localparam int DEST_LSB   = 16;
  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_LSB = 16;
  localparam int SRC1_MSB   = 10;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_MSB   = 2;
  localparam int SRC2_LSB   = 0;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Register write-back happens for data-processing opcodes only.
  function automatic logic op_writes(input logic [7:0] op);
    return (op <= OP_OR) || ((op >= OP_SLL) && (op <= OP_ROR));
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// 8-bit ALU: forward, add, and, or and the four shift/rotate operations.
`default_nettype none

module alu
  import cpu_pkg::*;
(
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [2:0] SELECT,
  output logic [7:0] RESULT,
  output logic       ZERO
);

  logic [2:0] rot;
  logic [15:0] rot_dbl;

  assign rot     = DATA2[2:0];
  assign rot_dbl = {DATA1, DATA1} >> rot;

  always_comb begin
    RESULT = 8'h00;
    case (SELECT)
      ALU_FWD: RESULT = DATA2;
      ALU_ADD: RESULT = DATA1 + DATA2;
      ALU_AND: RESULT = DATA1 & DATA2;
      ALU_OR:  RESULT = DATA1 | DATA2;
      ALU_SLL: RESULT = DATA1 << DATA2;
      ALU_SRL: RESULT = DATA1 >> DATA2;
      ALU_SRA: RESULT = $signed(DATA1) >>> DATA2;
      ALU_ROR: RESULT = rot_dbl[7:0];
      default: RESULT = 8'h00;
    endcase
  end

  assign ZERO = (RESULT == 8'h00);

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// 8x8 register file: two combinational read ports, one edge-triggered write
// port; an asynchronous active-low reset clears every entry.
`default_nettype none

module reg_file (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WRITE,
  input  logic [7:0] IN,
  input  logic [2:0] INADDR,
  input  logic [2:0] OUT1ADDR,
  input  logic [2:0] OUT2ADDR,
  output logic [7:0] OUT1,
  output logic [7:0] OUT2
);

  logic [7:0] regs_q [8];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else if (WRITE) begin
      regs_q[INADDR] <= IN;
    end
  end

  // Reads see the stored value, so a same-cycle write is visible only after the edge.
  assign OUT1 = regs_q[OUT1ADDR];
  assign OUT2 = regs_q[OUT2ADDR];

endmodule

`default_nettype wire

// File: rtl/cpu.sv
// Single-cycle 8-bit core: PC, next-PC logic, decoder and operand muxes
// around the register file and ALU.
`default_nettype none

module cpu
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] PC
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4, branch_target;

  logic [7:0] opcode, offset, imm;
  logic [2:0] dest, src1, src2;
  logic       unused_bits;

  logic [2:0] alu_select;
  logic       write_en, use_imm, negate, is_branch, is_jump;

  logic [7:0] rd1, rd2, neg_rd2, data2, alu_result;
  logic       alu_zero;

  assign opcode      = INSTRUCTION[OPCODE_MSB:OPCODE_LSB];
  assign dest        = INSTRUCTION[DEST_MSB:DEST_LSB];
  assign offset      = INSTRUCTION[OFFSET_MSB:OFFSET_LSB];
  assign src1        = INSTRUCTION[SRC1_MSB:SRC1_LSB];
  assign src2        = INSTRUCTION[SRC2_MSB:SRC2_LSB];
  assign imm         = INSTRUCTION[IMM_MSB:IMM_LSB];
  assign unused_bits = ^INSTRUCTION[15:11];

  always_comb begin
    alu_select = ALU_FWD;
    use_imm    = 1'b0;
    negate     = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    write_en   = op_writes(opcode);
    case (opcode)
      OP_LOADI: begin alu_select = ALU_FWD; use_imm = 1'b1; end
      OP_MOV:   alu_select = ALU_FWD;
      OP_ADD:   alu_select = ALU_ADD;
      OP_SUB:   begin alu_select = ALU_ADD; negate = 1'b1; end
      OP_AND:   alu_select = ALU_AND;
      OP_OR:    alu_select = ALU_OR;
      OP_J:     is_jump = 1'b1;
      OP_BEQ:   begin alu_select = ALU_ADD; negate = 1'b1; is_branch = 1'b1; end
      OP_SLL:   begin alu_select = ALU_SLL; use_imm = 1'b1; end
      OP_SRL:   begin alu_select = ALU_SRL; use_imm = 1'b1; end
      OP_SRA:   begin alu_select = ALU_SRA; use_imm = 1'b1; end
      OP_ROR:   begin alu_select = ALU_ROR; use_imm = 1'b1; end
      default:  ;
    endcase
  end

  assign neg_rd2 = ~rd2 + 8'd1;
  assign data2   = use_imm ? imm : (negate ? neg_rd2 : rd2);

  reg_file u_rf (
    .CLK      (CLK),
    .RESET    (RESET),
    .WRITE    (write_en),
    .IN       (alu_result),
    .INADDR   (dest),
    .OUT1ADDR (src1),
    .OUT2ADDR (src2),
    .OUT1     (rd1),
    .OUT2     (rd2)
  );

  alu u_alu (
    .DATA1  (rd1),
    .DATA2  (data2),
    .SELECT (alu_select),
    .RESULT (alu_result),
    .ZERO   (alu_zero)
  );

  // Word offset relative to the following instruction; wraps modulo 2^32.
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};
  assign pc_d          = (is_jump || (is_branch && alu_zero)) ? branch_target : pc_plus4;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign PC = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu.sv
// Directed bench for cpu: a vector table of instructions with expected PC and
// register contents, plus hand-written reset and jump sequences.
`default_nettype none

module tb_cpu;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic [31:0] PC;

  int n_checks = 0;
  int n_fail   = 0;

  cpu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC)
  );

  always #4 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_pc;
    int          ridx;
    logic [7:0]  rval;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] hi,
                                      input logic [2:0] s1, input logic [7:0] lo);
    return {op, hi, 5'b0, s1, lo};
  endfunction

  function automatic logic [31:0] rr(input logic [7:0] op, input logic [2:0] rd,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return enc(op, {5'b0, rd}, s1, {5'b0, s2});
  endfunction

  function automatic logic [31:0] ri(input logic [7:0] op, input logic [2:0] rd,
                                     input logic [2:0] s1, input logic [7:0] im);
    return enc(op, {5'b0, rd}, s1, im);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rdreg(input int idx);
    return dut.u_rf.regs_q[idx];
  endfunction

  task automatic step(input logic [31:0] instr);
    INSTRUCTION = instr;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{ri(8'h00, 3'd1, 3'd0, 8'd9),   32'h04, 1, 8'h09};
    vecs[1]  = '{ri(8'h00, 3'd2, 3'd0, 8'd9),   32'h08, 2, 8'h09};
    vecs[2]  = '{rr(8'h03, 3'd4, 3'd1, 3'd2),   32'h0C, 4, 8'h00};
    vecs[3]  = '{rr(8'h04, 3'd5, 3'd1, 3'd2),   32'h10, 5, 8'h09};
    vecs[4]  = '{enc(8'h07, 8'h02, 3'd1, 8'h02), 32'h1C, 4, 8'h00};
    vecs[5]  = '{ri(8'h00, 3'd2, 3'd0, 8'd8),   32'h20, 2, 8'h08};
    vecs[6]  = '{enc(8'h06, 8'hFD, 3'd0, 8'h00), 32'h18, 2, 8'h08};
    vecs[7]  = '{enc(8'h07, 8'h02, 3'd1, 8'h02), 32'h1C, 1, 8'h09};
    vecs[8]  = '{ri(8'h00, 3'd1, 3'd0, 8'h96),  32'h20, 1, 8'h96};
    vecs[9]  = '{ri(8'h08, 3'd2, 3'd1, 8'd2),   32'h24, 2, 8'h58};
    vecs[10] = '{ri(8'h09, 3'd3, 3'd1, 8'd1),   32'h28, 3, 8'h4B};
    vecs[11] = '{ri(8'h0A, 3'd6, 3'd1, 8'd1),   32'h2C, 6, 8'hCB};
    vecs[12] = '{ri(8'h0B, 3'd7, 3'd1, 8'd4),   32'h30, 7, 8'h69};
    vecs[13] = '{rr(8'h05, 3'd0, 3'd2, 3'd3),   32'h34, 0, 8'h5B};
    vecs[14] = '{rr(8'h01, 3'd5, 3'd0, 3'd7),   32'h38, 5, 8'h69};
    vecs[15] = '{ri(8'hFF, 3'd5, 3'd1, 8'h00),  32'h3C, 5, 8'h69};
    vecs[16] = '{rr(8'h03, 3'd4, 3'd3, 3'd2),   32'h40, 4, 8'hF3};

    RESET = 1'b0;
    #1;
    check("reset_pc", PC, 32'h0);
    check("reset_r3", {24'h0, rdreg(3)}, 32'h0);
    @(negedge CLK);
    check("held_pc", PC, 32'h0);
    RESET = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].instr);
      check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      check($sformatf("vec%0d_r%0d", i, vecs[i].ridx), {24'h0, rdreg(vecs[i].ridx)},
            {24'h0, vecs[i].rval});
    end

    // Jump from PC 0 with offset -1 wraps back to 0.
    pulse_reset();
    step(enc(8'h06, 8'hFF, 3'd0, 8'h00));
    check("j_m1_pc", PC, 32'h0);

    // Sub with borrow wrap: 3 - 5 = 0xFE.
    step(ri(8'h00, 3'd1, 3'd0, 8'd3));
    step(ri(8'h00, 3'd2, 3'd0, 8'd5));
    step(rr(8'h03, 3'd4, 3'd1, 3'd2));
    check("sub_wrap_r4", {24'h0, rdreg(4)}, 32'h0000_00FE);
    check("sub_wrap_pc", PC, 32'h0C);

    // Load/add from reset, then reset in the middle of an add to r5.
    pulse_reset();
    check("rst_clears_r4", {24'h0, rdreg(4)}, 32'h0);
    step(ri(8'h00, 3'd1, 3'd0, 8'd5));
    step(ri(8'h00, 3'd2, 3'd0, 8'd3));
    step(rr(8'h02, 3'd3, 3'd1, 3'd2));
    check("add_r3", {24'h0, rdreg(3)}, 32'h08);
    check("add_pc", PC, 32'h0C);
    INSTRUCTION = rr(8'h02, 3'd5, 3'd1, 3'd2);
    #2;
    RESET = 1'b0;
    #1;
    check("midrst_pc", PC, 32'h0);
    check("midrst_r5", {24'h0, rdreg(5)}, 32'h0);
    check("midrst_r1", {24'h0, rdreg(1)}, 32'h0);
    @(posedge CLK);
    #1;
    check("held_r5", {24'h0, rdreg(5)}, 32'h0);
    check("held_pc2", PC, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    step(ri(8'h00, 3'd1, 3'd0, 8'd7));
    check("restart_pc", PC, 32'h04);
    check("restart_r1", {24'h0, rdreg(1)}, 32'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
